// File: rtl/mcp_uart_port.sv
// mcp_uart_port: OUTPUT/INPUT strobe mapped UART for the mcp core.
// Buffered 8N1 transmitter, single-byte receiver, and pollable status byte.
`timescale 1ns/1ps
module mcp_uart_port #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TX_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] out_data,
    input  logic       out_strobe_n,
    output logic [7:0] in_data,
    input  logic       in_strobe_n,
    output logic [7:0] status,
    input  logic       status_strobe_n,
    output logic       txd,
    input  logic       rxd
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          out_q, in_q, st_q;
    logic          rs1, rs2, rs3;
    logic [7:0]    fifo [TX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    state_t        tx_state, tx_next, rx_state, rx_next;
    logic [CW-1:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n, rx_bit, rx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n, rx_shift, rx_shift_n;
    logic          txd_n, pop, push, rx_done;
    logic          rx_valid, rx_ovf, frame_err, tx_ovf;

    // Each strobe counts once, on its falling edge.
    wire wr_ev    = ~out_strobe_n & out_q;
    wire in_ev    = ~in_strobe_n & in_q;
    wire st_ev    = ~status_strobe_n & st_q;
    wire tx_full  = (count == FULL_CNT);
    wire tx_empty = (count == '0);
    wire tx_busy  = (tx_state != IDLE) | ~tx_empty;
    wire rx_load  = rx_done & rs2 & (~rx_valid | in_ev);
    wire rx_drop  = rx_done & rs2 & rx_valid & ~in_ev;
    wire rx_ferr  = rx_done & ~rs2;
    wire tx_drop  = wr_ev & tx_full & ~pop;

    assign push = wr_ev & (~tx_full | pop);

    always_comb begin
        tx_next    = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        pop        = 1'b0;
        unique case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    pop        = 1'b1;
                    tx_shift_n = fifo[rd_ptr];
                    tx_next    = START;
                end
            end
            START: if (tx_cnt == BIT_END) begin
                tx_cnt_n = '0;
                tx_bit_n = '0;
                tx_next  = DATA;
            end
            DATA: if (tx_cnt == BIT_END) begin
                tx_cnt_n   = '0;
                tx_shift_n = {1'b0, tx_shift[7:1]};
                tx_bit_n   = tx_bit + 3'd1;
                if (tx_bit == 3'd7) tx_next = STOP;
            end
            STOP: if (tx_cnt == BIT_END) begin
                tx_cnt_n = '0;
                tx_next  = IDLE;
            end
        endcase
        unique case (tx_next)
            START:   txd_n = 1'b0;
            DATA:    txd_n = tx_shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    // Start bit is re-checked at mid-bit; data and stop are sampled at bit centres.
    always_comb begin
        rx_next    = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        unique case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (rs3 && !rs2) rx_next = START;
            end
            START: if (rx_cnt == HALF_END) begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                rx_next  = rs2 ? IDLE : DATA;
            end
            DATA: if (rx_cnt == BIT_END) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rs2, rx_shift[7:1]};
                rx_bit_n   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_next = STOP;
            end
            STOP: if (rx_cnt == BIT_END) begin
                rx_cnt_n = '0;
                rx_done  = 1'b1;
                rx_next  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= out_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= 1'b1;
            in_q      <= 1'b1;
            st_q      <= 1'b1;
            rs1       <= 1'b1;
            rs2       <= 1'b1;
            rs3       <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            tx_state  <= IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            txd       <= 1'b1;
            rx_state  <= IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            in_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
            tx_ovf    <= 1'b0;
            status    <= 8'h04;
        end else begin
            out_q    <= out_strobe_n;
            in_q     <= in_strobe_n;
            st_q     <= status_strobe_n;
            rs1      <= rxd;
            rs2      <= rs1;
            rs3      <= rs2;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            txd      <= txd_n;
            rx_state <= rx_next;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            if (rx_load) begin
                in_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (in_ev) begin
                rx_valid <= 1'b0;
            end
            rx_ovf    <= rx_drop | (rx_ovf & ~st_ev);
            frame_err <= rx_ferr | (frame_err & ~st_ev);
            tx_ovf    <= tx_drop | (tx_ovf & ~st_ev);
            status    <= {1'b0, tx_ovf, frame_err, rx_ovf,
                          tx_busy, tx_empty, tx_full, rx_valid};
        end
    end
endmodule
